// File: rtl/four_bank_mem_pkg.sv
// Shared constants and helpers for the four-bank interleaved memory responder.
// Address map: bank = addr[2:1], row = addr[15:3], addr[0] selects a byte
// within the 16-bit word.
package four_bank_mem_pkg;

  localparam int NUM_BANKS = 4;
  localparam int WORD_W    = 16;
  localparam int ADDR_W    = 16;
  localparam int BANK_LSB  = 1;
  localparam int BANK_MSB  = 2;
  localparam int ROW_LSB   = 3;
  localparam int BANK_W    = BANK_MSB - BANK_LSB + 1;

  // Width of the per-bank occupancy counter; holds BANK_CYCLES-1 up to 14.
  localparam int CNT_W     = 4;

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [BANK_W-1:0] bank_idx_t;

  // Extract the bank index from a byte address.
  function automatic bank_idx_t bank_of(input logic [ADDR_W-1:0] a);
    return a[BANK_MSB:BANK_LSB];
  endfunction

endpackage

// File: rtl/four_bank_mem_bank.sv
// One memory bank: storage array, occupancy counter, accept-gated write and
// a registered read word that feeds stage 1 of the shared read pipeline.
// Storage is intentionally not reset; its contents are undefined until written.
module mem_bank
  import four_bank_mem_pkg::*;
#(
  parameter int BANK_CYCLES = 4,
  parameter int ROWS        = 8192,
  localparam int ROW_W      = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             acc_i,
  input  logic             wr_i,
  input  logic [ROW_W-1:0] row_i,
  input  word_t            wdata_i,
  output logic             busy_o,
  output word_t            rdata_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  word_t            rdata_q;
  word_t            rdata_d;
  word_t            mem_q [ROWS];

  // Next-state for the occupancy counter and the captured read word.
  always_comb begin
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    if (acc_i) begin
      cnt_d = CNT_W'(BANK_CYCLES - 1);
    end else if (cnt_q != {CNT_W{1'b0}}) begin
      cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
    if (acc_i && !wr_i) begin
      rdata_d = mem_q[row_i];
    end else begin
      rdata_d = rdata_q;
    end
  end

  // Counter and read-word registers, cleared by the asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= {CNT_W{1'b0}};
      rdata_q <= {WORD_W{1'b0}};
    end else begin
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
    end
  end

  // Storage write on an accepted write request; no reset on the array.
  always_ff @(posedge clk) begin
    if (acc_i && wr_i) begin
      mem_q[row_i] <= wdata_i;
    end
  end

  assign busy_o  = (cnt_q != {CNT_W{1'b0}});
  assign rdata_o = rdata_q;

endmodule

// File: rtl/four_bank_mem.sv
// Four interleaved 16-bit banks answering cache line fills and evictions.
// The top decodes the target bank, raises stall/err combinationally and
// runs the two-stage read pipeline so data_out lags the accept edge by one
// further edge. Optional build macro MEM_ALIGN_CHK_EN: when defined, an odd
// byte address on any request raises err and the request is dropped; when
// undefined, addr[0] is ignored and the containing word is accessed.
module four_bank_mem
  import four_bank_mem_pkg::*;
#(
  parameter int BANK_CYCLES = 4,
  parameter int ROWS        = 8192
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] addr,
  input  logic [15:0] data_in,
  input  logic        wr,
  input  logic        rd,
  output logic [15:0] data_out,
  output logic [3:0]  busy,
  output logic        stall,
  output logic        err
);

  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;

  logic                 req_s;
  logic                 err_s;
  logic                 stall_s;
  logic                 acc_s;
  bank_idx_t            bank_s;
  logic [ROW_W-1:0]     row_s;
  logic [NUM_BANKS-1:0] busy_s;
  word_t                bank_rdata_s [NUM_BANKS];
  logic                 addr_unused_s;

  logic                 s1_valid_q;
  logic                 s1_valid_d;
  bank_idx_t            s1_bank_q;
  bank_idx_t            s1_bank_d;
  word_t                data_out_q;
  word_t                data_out_d;

  // Some address bits are not needed in every build (addr[0], high row bits).
  assign addr_unused_s = ^addr;

  // Request decode: bank/row split, error, stall and accept.
  always_comb begin
    req_s  = wr | rd;
    bank_s = bank_of(addr);
    row_s  = addr[ROW_LSB +: ROW_W];
`ifdef MEM_ALIGN_CHK_EN
    err_s  = (wr & rd) | (req_s & addr[0]);
`else
    err_s  = wr & rd;
`endif
    stall_s = req_s & busy_s[bank_s] & ~err_s;
    acc_s   = req_s & ~busy_s[bank_s] & ~err_s;
  end

  // One bank instance per interleave slot; only the addressed bank sees accept.
  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    mem_bank #(
      .BANK_CYCLES (BANK_CYCLES),
      .ROWS        (ROWS)
    ) u_bank (
      .clk     (clk),
      .rst_n   (rst),
      .acc_i   (acc_s && (bank_s == BANK_W'(b))),
      .wr_i    (wr),
      .row_i   (row_s),
      .wdata_i (data_in),
      .busy_o  (busy_s[b]),
      .rdata_o (bank_rdata_s[b])
    );
  end

  // Read pipeline next-state: stage 1 remembers which bank holds the word,
  // stage 2 drives the word out or zero when nothing is in flight.
  always_comb begin
    s1_valid_d = acc_s & rd;
    if (s1_valid_d) begin
      s1_bank_d = bank_s;
    end else begin
      s1_bank_d = s1_bank_q;
    end
    if (s1_valid_q) begin
      data_out_d = bank_rdata_s[s1_bank_q];
    end else begin
      data_out_d = {WORD_W{1'b0}};
    end
  end

  // Pipeline registers; reset discards any in-flight read.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid_q <= 1'b0;
      s1_bank_q  <= {BANK_W{1'b0}};
      data_out_q <= {WORD_W{1'b0}};
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_bank_q  <= s1_bank_d;
      data_out_q <= data_out_d;
    end
  end

  assign data_out = data_out_q;
  assign busy     = busy_s;
  assign stall    = stall_s;
  assign err      = err_s;

endmodule
